bcp_scheduler: RTL

Boolean-constraint-propagation scheduler for the DPLL SAT solver. Holds a queue of pending literal assignments (the decision seed plus the implications that the clause units return). Dispatches each literal round-robin to a pool of clause-evaluation units. Reports back to the top-level solver control FSM when propagation has finished, either cleanly or with a conflict. The control FSM starts it from BCP_INIT and waits on it in BCP_WAIT.

---
 rtl/bcp_scheduler.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/bcp_scheduler.sv
// ---------------------------------------------------------------------------
// bcp_scheduler
//
// Boolean-constraint-propagation scheduler for the DPLL SAT solver. It keeps
// a FIFO of pending literal assignments (the decision seed followed by the
// implications returned by the clause units), hands each literal to a free
// clause-evaluation unit in round-robin order, and tells the solver control
// FSM when propagation has finished, cleanly or with a conflict.
//
// Ports
//   clock, reset            rising-edge clock, asynchronous active-high reset
//   start, seed_var/val     begin BCP with a decided literal (IDLE only)
//   imp_valid/var/val       implication offered by the units
//   imp_ready               implication accepted when imp_valid & imp_ready
//   conflict                some unit found a falsified clause
//   disp_valid/var/val      one-hot dispatch of the queue head to a unit
//   unit_done               per-unit completion pulse
//   busy                    scheduler is not in IDLE
//   bcp_done, bcp_conflict  one-cycle completion pulse and its outcome
// ---------------------------------------------------------------------------
module bcp_scheduler #(
   parameter int NUM_VARIABLE = 128,
   parameter int VAR_INDEX    = 7,
   parameter int NUM_UNITS    = 4,
   parameter int QUEUE_DEPTH  = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   input  logic [VAR_INDEX-1:0] seed_var,
   input  logic                 seed_val,
   input  logic                 imp_valid,
   input  logic [VAR_INDEX-1:0] imp_var,
   input  logic                 imp_val,
   output logic                 imp_ready,
   input  logic                 conflict,
   output logic [NUM_UNITS-1:0] disp_valid,
   output logic [VAR_INDEX-1:0] disp_var,
   output logic                 disp_val,
   input  logic [NUM_UNITS-1:0] unit_done,
   output logic                 busy,
   output logic                 bcp_done,
   output logic                 bcp_conflict
);

   // Queue entries hold {variable, value}; the variable field is sized from
   // the variable count, which must match VAR_INDEX.
   localparam int VarW   = $clog2(NUM_VARIABLE);
   localparam int EntryW = VarW + 1;
   localparam int PtrW   = $clog2(QUEUE_DEPTH);
   localparam int RrW    = $clog2(NUM_UNITS);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

   state_e               state_q, state_d;
   logic [EntryW-1:0]    queue_mem [QUEUE_DEPTH];
   logic [PtrW-1:0]      head_q, head_d, tail_q, tail_d;
   logic [PtrW:0]        count_q, count_d;
   logic [NUM_UNITS-1:0] unit_busy_q, unit_busy_d;
   logic [RrW-1:0]       rr_ptr_q, rr_ptr_d;
   logic                 conflict_q, conflict_d;

   logic                 write_en;
   logic [EntryW-1:0]    write_entry;
   logic                 push;
   logic                 pop;
   logic                 queue_empty;
   logic                 grant_found;
   logic [RrW-1:0]       grant_idx;
   logic [RrW-1:0]       scan_idx;
   logic [NUM_UNITS-1:0] grant;

   assign queue_empty = (count_q == '0);

   // Round-robin arbiter: first free unit scanning upward from rr_ptr_q.
   // Only registered state is used, so a unit whose done pulse arrives this
   // cycle still counts as busy.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      scan_idx    = '0;
      grant       = '0;
      for (int i = 0; i < NUM_UNITS; i++) begin
         scan_idx = rr_ptr_q + RrW'(i);
         if (!grant_found && !unit_busy_q[scan_idx]) begin
            grant_found = 1'b1;
            grant_idx   = scan_idx;
         end
      end
      if (state_q == RUN && !queue_empty && grant_found) begin
         grant = NUM_UNITS'(1) << grant_idx;
      end
   end

   assign pop          = |grant;
   assign disp_valid   = grant;
   assign disp_var     = pop ? queue_mem[head_q][EntryW-1:1] : '0;
   assign disp_val     = pop ? queue_mem[head_q][0] : 1'b0;
   assign busy         = (state_q != IDLE);
   assign bcp_done     = (state_q == DONE);
   assign bcp_conflict = (state_q == DONE) && conflict_q;

   // DRAIN accepts and drops implications so upstream units never stall.
   always_comb begin
      imp_ready = 1'b0;
      if (state_q == RUN) begin
         imp_ready = (count_q < (PtrW+1)'(QUEUE_DEPTH));
      end else if (state_q == DRAIN) begin
         imp_ready = 1'b1;
      end
   end

   // Next-state logic for the FSM, queue pointers, unit tracking and the
   // conflict latch. A conflict flushes the queue immediately; the dispatch
   // made in that same cycle still marks its unit busy so DRAIN waits for it.
   always_comb begin
      state_d     = state_q;
      head_d      = head_q;
      tail_d      = tail_q;
      count_d     = count_q;
      unit_busy_d = unit_busy_q;
      rr_ptr_d    = rr_ptr_q;
      conflict_d  = conflict_q;
      write_en    = 1'b0;
      write_entry = {seed_var, seed_val};
      push        = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               write_en = 1'b1;
               tail_d   = tail_q + 1'b1;
               count_d  = (PtrW+1)'(1);
               state_d  = RUN;
            end
         end
         RUN: begin
            push = imp_valid && imp_ready;
            if (push) begin
               write_en    = 1'b1;
               write_entry = {imp_var, imp_val};
               tail_d      = tail_q + 1'b1;
            end
            if (pop) begin
               head_d   = head_q + 1'b1;
               rr_ptr_d = grant_idx + 1'b1;
            end
            count_d     = count_q + {{PtrW{1'b0}}, push} - {{PtrW{1'b0}}, pop};
            unit_busy_d = (unit_busy_q & ~unit_done) | grant;
            if (conflict) begin
               conflict_d = 1'b1;
               head_d     = '0;
               tail_d     = '0;
               count_d    = '0;
               state_d    = (unit_busy_q == '0 && !pop) ? DONE : DRAIN;
            end else if (queue_empty && unit_busy_q == '0 && !imp_valid) begin
               state_d = DONE;
            end
         end
         DRAIN: begin
            unit_busy_d = unit_busy_q & ~unit_done;
            if (unit_busy_q == '0) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d    = IDLE;
            conflict_d = 1'b0;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            rr_ptr_d   = '0;
         end
         default: state_d = IDLE;
      endcase
   end

   // Control state register; reset abandons any in-flight work silently.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         unit_busy_q <= '0;
         rr_ptr_q    <= '0;
         conflict_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         unit_busy_q <= unit_busy_d;
         rr_ptr_q    <= rr_ptr_d;
         conflict_q  <= conflict_d;
      end
   end

   // Queue storage needs no reset: entries are only read while count_q
   // says they are valid, and the dispatch outputs are gated by pop.
   always_ff @(posedge clock) begin
      if (write_en) begin
         queue_mem[tail_q] <= write_entry;
      end
   end

endmodule
